instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch_if.sv | 24 ++
 rtl/instruction_fetch.sv | 122 ++++++++++++
 tb/tb_instruction_fetch.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Bundle between the fetch stage, instruction memory (wait-request read port)
// and the downstream instruction queue push side.
interface instruction_fetch_if;
   logic        queue_full;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic [31:0] imem_addr;
   logic        imem_rd;
   logic        imem_waitrequest;
   logic [31:0] imem_rdata;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        is_enqueue;

   modport master (
      input  queue_full, branch_valid, branch_target, imem_waitrequest, imem_rdata,
      output imem_addr, imem_rd, instr_out, instr_pc, is_enqueue
   );

   modport slave (
      output queue_full, branch_valid, branch_target, imem_waitrequest, imem_rdata,
      input  imem_addr, imem_rd, instr_out, instr_pc, is_enqueue
   );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one word read per two cycles, pushes words
// into the instruction queue, and handles branch redirects and back-pressure.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic                clk,
   input  logic                rst,
   instruction_fetch_if.master bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_r, state_s;
   logic [31:0] pc_r, pc_s;
   logic [31:0] req_pc_r, req_pc_s;
   logic [31:0] hold_data_r, hold_data_s;
   logic [31:0] hold_pc_r, hold_pc_s;
   logic        hold_valid_r, hold_valid_s;
   logic        squash_r, squash_s;
   logic        stall_r, stall_s;
   logic        enq_r, enq_s;
   logic [31:0] instr_r, instr_s;
   logic [31:0] instr_pc_r, instr_pc_s;
   logic        rd_s;
   logic        accept_s;

   assign bus.imem_addr  = pc_r;
   assign bus.imem_rd    = rd_s;
   assign bus.is_enqueue = enq_r;
   assign bus.instr_out  = instr_r;
   assign bus.instr_pc   = instr_pc_r;

   // stall_r keeps a waited-on request asserted even if queue_full rises meanwhile
   assign rd_s     = (state_r == REQ) && (stall_r || (!hold_valid_r && !bus.queue_full));
   assign accept_s = rd_s && !bus.imem_waitrequest;

   // Next-state and datapath decode
   always_comb begin
      state_s      = state_r;
      pc_s         = pc_r;
      req_pc_s     = req_pc_r;
      hold_data_s  = hold_data_r;
      hold_pc_s    = hold_pc_r;
      hold_valid_s = hold_valid_r;
      squash_s     = (state_r == RESP) ? 1'b0 : squash_r;
      stall_s      = rd_s && bus.imem_waitrequest && !bus.branch_valid;
      enq_s        = 1'b0;
      instr_s      = instr_r;
      instr_pc_s   = instr_pc_r;

      case (state_r)
         IDLE:    state_s = REQ;
         REQ:     state_s = accept_s ? RESP : REQ;
         RESP:    state_s = REQ;
         default: state_s = IDLE;
      endcase

      if (bus.branch_valid) begin
         // Redirect wins over everything; data arriving in RESP is simply not used
         pc_s         = bus.branch_target & ~32'd3;
         hold_valid_s = 1'b0;
         squash_s     = accept_s;
      end else begin
         if (accept_s) begin
            pc_s     = pc_r + PC_STEP;
            req_pc_s = pc_r;
         end else begin
            pc_s = pc_r;
         end

         if (state_r == RESP && !squash_r && !bus.queue_full) begin
            enq_s      = 1'b1;
            instr_s    = bus.imem_rdata;
            instr_pc_s = req_pc_r;
         end else if (state_r == RESP && !squash_r) begin
            hold_valid_s = 1'b1;
            hold_data_s  = bus.imem_rdata;
            hold_pc_s    = req_pc_r;
         end else if (hold_valid_r && !bus.queue_full) begin
            enq_s        = 1'b1;
            instr_s      = hold_data_r;
            instr_pc_s   = hold_pc_r;
            hold_valid_s = 1'b0;
         end else begin
            enq_s = 1'b0;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         pc_r         <= RESET_PC;
         req_pc_r     <= 32'h0000_0000;
         hold_data_r  <= 32'h0000_0000;
         hold_pc_r    <= 32'h0000_0000;
         hold_valid_r <= 1'b0;
         squash_r     <= 1'b0;
         stall_r      <= 1'b0;
         enq_r        <= 1'b0;
         instr_r      <= 32'h0000_0000;
         instr_pc_r   <= 32'h0000_0000;
      end else begin
         state_r      <= state_s;
         pc_r         <= pc_s;
         req_pc_r     <= req_pc_s;
         hold_data_r  <= hold_data_s;
         hold_pc_r    <= hold_pc_s;
         hold_valid_r <= hold_valid_s;
         squash_r     <= squash_s;
         stall_r      <= stall_s;
         enq_r        <= enq_s;
         instr_r      <= instr_s;
         instr_pc_r   <= instr_pc_s;
      end
   end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: cycle tables, directed corner sequences and a
// randomized run checked against an instruction-stream reference model.
module tb_instruction_fetch;
   logic clk = 1'b0;
   logic rst = 1'b1;
   instruction_fetch_if bus();

   instruction_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        qf;
      logic        wr;
      logic        bv;
      logic [31:0] bt;
      logic        e_enq;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_rd;
      logic [31:0] e_addr;
   } vec_t;

   int          total = 0;
   int          bad = 0;
   int          cyc_cnt = 0;
   logic        acc_r = 1'b0;
   logic [31:0] acc_addr = 32'h0;
   logic        obs_enq, obs_rd;
   logic [31:0] obs_pc, obs_instr, obs_addr;
   vec_t        tbl[$];

   function automatic vec_t mk(input logic qf, input logic wr, input logic bv, input logic [31:0] bt,
                               input logic ee, input logic [31:0] ep, input logic [31:0] ei,
                               input logic er, input logic [31:0] ea);
      vec_t v;
      v.qf = qf; v.wr = wr; v.bv = bv; v.bt = bt;
      v.e_enq = ee; v.e_pc = ep; v.e_instr = ei; v.e_rd = er; v.e_addr = ea;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One clock: sample registered outputs, drive inputs, then sample the read port.
   task automatic step(input logic qf, input logic wr, input logic bv, input logic [31:0] bt);
      @(posedge clk);
      #1;
      cyc_cnt++;
      obs_enq   = bus.is_enqueue;
      obs_pc    = bus.instr_pc;
      obs_instr = bus.instr_out;
      bus.imem_rdata       = acc_r ? (acc_addr + 32'h0000_1000) : (32'hBAD0_0000 | 32'(cyc_cnt));
      bus.queue_full       = qf;
      bus.imem_waitrequest = wr;
      bus.branch_valid     = bv;
      bus.branch_target    = bt;
      #1;
      obs_rd   = bus.imem_rd;
      obs_addr = bus.imem_addr;
      acc_r    = obs_rd && !wr;
      acc_addr = obs_addr;
   endtask

   task automatic cyc_chk(input string nm, input vec_t v);
      step(v.qf, v.wr, v.bv, v.bt);
      chk({nm, ".enq"}, 32'(obs_enq), 32'(v.e_enq));
      if (v.e_enq) begin
         chk({nm, ".pc"}, obs_pc, v.e_pc);
         chk({nm, ".instr"}, obs_instr, v.e_instr);
      end
      chk({nm, ".rd"}, 32'(obs_rd), 32'(v.e_rd));
      chk({nm, ".addr"}, obs_addr, v.e_addr);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      acc_r = 1'b0;
      bus.queue_full = 1'b0;
      bus.imem_waitrequest = 1'b0;
      bus.branch_valid = 1'b0;
      bus.branch_target = 32'h0;
      bus.imem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Three cycles from reset release up to the enqueue of pc 0.
   task automatic warmup(input string nm);
      cyc_chk(nm, mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0));
      cyc_chk(nm, mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4));
      cyc_chk(nm, mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h1000, 1'b1, 32'h4));
   endtask

   initial begin
      logic        qf, wr, bv, p_qf, p_wr, p_bv, p_rd;
      logic [31:0] bt, p_addr, exp_next;
      int          n_enq;

      // Reset values
      do_reset();
      rst = 1'b1;
      #1;
      chk("rst.enq", 32'(bus.is_enqueue), 32'd0);
      chk("rst.rd", 32'(bus.imem_rd), 32'd0);
      chk("rst.addr", bus.imem_addr, 32'h0);
      chk("rst.instr", bus.instr_out, 32'h0);
      chk("rst.pc", bus.instr_pc, 32'h0);

      // Streaming from reset, then a 3-cycle waitrequest on address 8
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,    1'b1, 32'h0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,    1'b0, 32'h4));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h1000, 1'b1, 32'h4));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,    1'b0, 32'h8));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 32'h1004, 1'b1, 32'h8));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,    1'b1, 32'h8));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,    1'b1, 32'h8));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,    1'b1, 32'h8));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,    1'b0, 32'hC));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 32'h1008, 1'b1, 32'hC));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,    1'b0, 32'h10));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC, 32'h100C, 1'b1, 32'h10));
      do_reset();
      for (int i = 0; i < tbl.size(); i++) cyc_chk($sformatf("tbl%0d", i), tbl[i]);

      // queue_full rises in the RESP cycle of pc 4: word held, then drained
      do_reset();
      warmup("hold");
      cyc_chk("hold", mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,    1'b0, 32'h8));
      cyc_chk("hold", mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,    1'b0, 32'h8));
      cyc_chk("hold", mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,    1'b0, 32'h8));
      cyc_chk("hold", mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 32'h1004, 1'b1, 32'h8));
      cyc_chk("hold", mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,    1'b0, 32'hC));
      cyc_chk("hold", mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 32'h1008, 1'b1, 32'hC));

      // Branch to 0x103 during the RESP cycle of pc 8
      do_reset();
      warmup("brresp");
      cyc_chk("brresp", mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,    1'b0, 32'h8));
      cyc_chk("brresp", mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'h1004, 1'b1, 32'h8));
      cyc_chk("brresp", mk(1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 32'h0,   32'h0,    1'b0, 32'hC));
      cyc_chk("brresp", mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,    1'b1, 32'h100));
      cyc_chk("brresp", mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,    1'b0, 32'h104));
      cyc_chk("brresp", mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h1100, 1'b1, 32'h104));

      // Branch while a word sits in the hold register
      do_reset();
      warmup("brhold");
      cyc_chk("brhold", mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,    1'b0, 32'h8));
      cyc_chk("brhold", mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,    1'b0, 32'h8));
      cyc_chk("brhold", mk(1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0,   32'h0,    1'b0, 32'h8));
      cyc_chk("brhold", mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,    1'b1, 32'h200));
      cyc_chk("brhold", mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,    1'b0, 32'h204));
      cyc_chk("brhold", mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 32'h1200, 1'b1, 32'h204));

      // Branch in the same cycle a request is accepted: that data is squashed
      do_reset();
      cyc_chk("brsq", mk(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0,   32'h0,    1'b1, 32'h0));
      cyc_chk("brsq", mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,    1'b0, 32'h300));
      cyc_chk("brsq", mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,    1'b1, 32'h300));
      cyc_chk("brsq", mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,    1'b0, 32'h304));
      cyc_chk("brsq", mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 32'h1300, 1'b1, 32'h304));

      // Reset asserted during RESP with valid read data
      do_reset();
      warmup("rstmid");
      cyc_chk("rstmid", mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h8));
      rst = 1'b1;
      #1;
      chk("rstmid.enq", 32'(bus.is_enqueue), 32'd0);
      chk("rstmid.instr", bus.instr_out, 32'h0);
      chk("rstmid.rd", 32'(bus.imem_rd), 32'd0);
      chk("rstmid.addr", bus.imem_addr, 32'h0);
      do_reset();
      cyc_chk("rstmid2", mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0));
      cyc_chk("rstmid2", mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4));
      cyc_chk("rstmid2", mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h1000, 1'b1, 32'h4));

      // Random run against the instruction-stream model
      do_reset();
      exp_next = 32'h0;
      n_enq = 0;
      p_qf = 1'b0; p_wr = 1'b0; p_bv = 1'b0; p_rd = 1'b0; p_addr = 32'h0;
      for (int i = 0; i < 3000; i++) begin
         qf = ($urandom_range(0, 3) == 0);
         wr = ($urandom_range(0, 3) == 0);
         bv = ($urandom_range(0, 39) == 0);
         bt = ($urandom_range(0, 1) == 1) ? 32'($urandom) : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
         step(qf, wr, bv, bt);
         if (obs_enq) begin
            n_enq++;
            chk("rand.enq_when_full", 32'(p_qf), 32'd0);
            chk("rand.pc", obs_pc, exp_next);
            chk("rand.instr", obs_instr, exp_next + 32'h0000_1000);
            exp_next = exp_next + 32'd4;
         end
         if (p_rd && p_wr && !p_bv) begin
            chk("rand.rd_stable", 32'(obs_rd), 32'd1);
            chk("rand.addr_stable", obs_addr, p_addr);
         end
         if (bv) exp_next = bt & ~32'd3;
         p_qf = qf; p_wr = wr; p_bv = bv; p_rd = obs_rd; p_addr = obs_addr;
      end
      chk("rand.progress", 32'(n_enq > 100), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
